// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// A single transaction is in flight at a time. Its request fields stay frozen
// until the mmu signals completion. The owner then sees a one-cycle ready pulse.
// Optional feature: define MEM_ARB_FAIRNESS_EN to stop data requests from
// starving fetch indefinitely. After FAIR_LIMIT consecutive data grants made
// while fetch was waiting, fetch is granted once. The default build uses
// strict data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int FAIR_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_drdy,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_write,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic            dm_rdu,
    input  logic            dm_hwrd,
    input  logic            dm_wrd,
    output logic            dm_drdy,
    output logic [XLEN-1:0] dm_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_rdu,
    output logic            mem_hwrd,
    output logic            mem_wrd,
    input  logic            mem_drdy,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          state_r, state_n;
    logic [XLEN-1:0] mem_addr_r, mem_addr_n, mem_wdata_r, mem_wdata_n;
    logic            mem_read_r, mem_read_n, mem_write_r, mem_write_n;
    logic            mem_rdu_r, mem_rdu_n, mem_hwrd_r, mem_hwrd_n, mem_wrd_r, mem_wrd_n;
    logic [XLEN-1:0] if_rdata_r, if_rdata_n, dm_rdata_r, dm_rdata_n;
    logic            if_drdy_r, if_drdy_n, dm_drdy_r, dm_drdy_n;
    logic            fair_hit_s;
    owner_t          own_s;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
    logic [CNT_W-1:0] fair_cnt_r;

    // Fetch wins a contested IDLE slot once data has had its quota of grants.
    assign fair_hit_s = (fair_cnt_r == CNT_W'(FAIR_LIMIT)) && dm_req && if_req;

    // Count data grants that made a waiting fetch wait longer; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt_r <= '0;
        end else if (state_r == IDLE && own_s == OWN_D) begin
            if (if_req && fair_cnt_r != CNT_W'(FAIR_LIMIT)) begin
                fair_cnt_r <= fair_cnt_r + CNT_W'(1);
            end else if (if_req) begin
                fair_cnt_r <= fair_cnt_r;
            end else begin
                fair_cnt_r <= '0;
            end
        end else if (state_r == IDLE && if_req) begin
            fair_cnt_r <= '0;
        end else begin
            fair_cnt_r <= fair_cnt_r;
        end
    end
`else
    // Strict data priority: never forces a fetch grant (the comparison is
    // constant false and only keeps FAIR_LIMIT referenced in this build).
    assign fair_hit_s = (FAIR_LIMIT < 0);
`endif

    // Owner of the next grant when IDLE: data unless fairness forces fetch.
    assign own_s = (dm_req && !fair_hit_s) ? OWN_D : OWN_I;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_n     = state_r;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        mem_read_n  = mem_read_r;
        mem_write_n = mem_write_r;
        mem_rdu_n   = mem_rdu_r;
        mem_hwrd_n  = mem_hwrd_r;
        mem_wrd_n   = mem_wrd_r;
        if_rdata_n  = if_rdata_r;
        dm_rdata_n  = dm_rdata_r;
        if_drdy_n   = 1'b0;
        dm_drdy_n   = 1'b0;
        case (state_r)
            IDLE: begin
                if (own_s == OWN_D) begin
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    mem_read_n  = ~dm_write;
                    mem_write_n = dm_write;
                    mem_rdu_n   = dm_rdu;
                    mem_hwrd_n  = dm_hwrd;
                    mem_wrd_n   = dm_wrd;
                    state_n     = BUSY_D;
                end else if (if_req) begin
                    mem_addr_n  = if_addr;
                    mem_wdata_n = '0;
                    mem_read_n  = 1'b1;
                    mem_write_n = 1'b0;
                    mem_rdu_n   = 1'b0;
                    mem_hwrd_n  = 1'b0;
                    mem_wrd_n   = 1'b1;
                    state_n     = BUSY_I;
                end else begin
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                end
            end
            BUSY_I: begin
                if (mem_drdy) begin
                    if_rdata_n  = mem_rdata;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    if_drdy_n   = 1'b1;
                    state_n     = DONE_I;
                end else begin
                    state_n = BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_drdy) begin
                    // A store leaves the load-data register untouched.
                    if (mem_read_r) begin
                        dm_rdata_n = mem_rdata;
                    end else begin
                        dm_rdata_n = dm_rdata_r;
                    end
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    dm_drdy_n   = 1'b1;
                    state_n     = DONE_D;
                end else begin
                    state_n = BUSY_D;
                end
            end
            DONE_I:  state_n = IDLE;
            DONE_D:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_rdu_r   <= 1'b0;
            mem_hwrd_r  <= 1'b0;
            mem_wrd_r   <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            if_drdy_r   <= 1'b0;
            dm_drdy_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
            mem_read_r  <= mem_read_n;
            mem_write_r <= mem_write_n;
            mem_rdu_r   <= mem_rdu_n;
            mem_hwrd_r  <= mem_hwrd_n;
            mem_wrd_r   <= mem_wrd_n;
            if_rdata_r  <= if_rdata_n;
            dm_rdata_r  <= dm_rdata_n;
            if_drdy_r   <= if_drdy_n;
            dm_drdy_r   <= dm_drdy_n;
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_rdu   = mem_rdu_r;
    assign mem_hwrd  = mem_hwrd_r;
    assign mem_wrd   = mem_wrd_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_drdy   = if_drdy_r;
    assign dm_drdy   = dm_drdy_r;

endmodule
